// File: rtl/lbdr_pkg.sv
// lbdr_pkg: flit codes, port indices and allocator state shared by the router blocks
package lbdr_pkg;
  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;
  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_W = 2;
  localparam int PORT_S = 3;
  localparam int PORT_L = 4;
  typedef enum logic {IDLE, ACTIVE} alloc_state_t;
endpackage

// File: rtl/lbdr_output_allocator_if.sv
// lbdr_output_allocator_if: request/grant/credit bundle between input ports and one output allocator
interface lbdr_output_allocator_if #(parameter int NUM_IN = 5, parameter int CW = 3);
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] empty;
  logic [3*NUM_IN-1:0] flit_id;
  logic credit_in;
  logic [NUM_IN-1:0] grant;
  logic [2:0] sel;
  logic [NUM_IN-1:0] rd_en;
  logic valid_out;
  logic [CW-1:0] credit_cnt;
  logic busy;
  logic abort;
  modport slave (input req, empty, flit_id, credit_in, output grant, sel, rd_en, valid_out, credit_cnt, busy, abort);
  modport master (output req, empty, flit_id, credit_in, input grant, sel, rd_en, valid_out, credit_cnt, busy, abort);
endinterface

// File: rtl/lbdr_output_allocator_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning from the input after i_ptr
module rr_arbiter #(parameter int NUM_IN = 5) (
  input  logic [NUM_IN-1:0] i_elig,
  input  logic [2:0]        i_ptr,
  output logic [NUM_IN-1:0] o_win,
  output logic [2:0]        o_idx
);
  function automatic logic [2:0] wrap(input logic [2:0] p, input int k);
    return 3'((int'(p) + k) % NUM_IN);
  endfunction
  // scan farthest first so the nearest eligible input overwrites
  always_comb begin
    o_win = '0;
    o_idx = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      if (i_elig[wrap(i_ptr, k)]) begin
        o_win = '0;
        o_win[wrap(i_ptr, k)] = 1'b1;
        o_idx = wrap(i_ptr, k);
      end
    end
  end
endmodule

// File: rtl/lbdr_output_allocator.sv
// lbdr_output_allocator: per-output round-robin packet allocator with downstream credit gating.
// Define ALLOC_TIMEOUT_EN to add a stall watchdog that drops ownership after TIMEOUT_CYC idle cycles.
module lbdr_output_allocator
  import lbdr_pkg::*;
#(
  parameter int NUM_IN = 5,
  parameter int CREDIT_DEPTH = 4,
  parameter int CW = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input logic clk,
  input logic rst,
  lbdr_output_allocator_if.slave bus
);
  if ((1 << CW) <= CREDIT_DEPTH) $error("CW too narrow for CREDIT_DEPTH");
  if (TIMEOUT_CYC < 1) $error("TIMEOUT_CYC must be positive");
  alloc_state_t r_state, w_state_nx;
  logic [NUM_IN-1:0] r_grant, w_grant_nx, w_elig, w_win;
  logic [2:0] r_sel, w_sel_nx, r_ptr, w_ptr_nx, w_win_idx;
  logic [CW-1:0] r_credit, w_credit_nx;
  logic [2:0] w_fid [NUM_IN];
  logic w_go, w_tail, w_to;
  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign w_fid[i] = bus.flit_id[3*i +: 3];
    assign w_elig[i] = bus.req[i] & ~bus.empty[i] & (w_fid[i] == HEADER);
  end
  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (.i_elig(w_elig), .i_ptr(r_ptr), .o_win(w_win), .o_idx(w_win_idx));
  assign w_go = (r_state == ACTIVE) & ~bus.empty[r_sel] & (r_credit != '0);
  assign w_tail = w_go & (w_fid[r_sel] == TAIL);
`ifdef ALLOC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wd;
  logic r_abort;
  assign w_to = (r_state == ACTIVE) & ~w_go & (r_wd == TW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd <= '0;
      r_abort <= 1'b0;
    end else begin
      r_wd <= (r_state != ACTIVE || w_go || w_to) ? '0 : r_wd + 1'b1;
      r_abort <= w_to;
    end
  end
  assign bus.abort = r_abort;
`else
  assign w_to = 1'b0;
  assign bus.abort = 1'b0;
`endif
  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_sel_nx = r_sel;
    w_ptr_nx = r_ptr;
    if (r_state == IDLE && |w_elig) begin
      w_state_nx = ACTIVE;
      w_grant_nx = w_win;
      w_sel_nx = w_win_idx;
    end else if (r_state == ACTIVE && (w_tail || w_to)) begin
      w_state_nx = IDLE;
      w_grant_nx = '0;
      w_ptr_nx = r_sel;
    end
    w_credit_nx = (w_go == bus.credit_in) ? r_credit :
                  w_go ? r_credit - 1'b1 :
                  (r_credit == CW'(CREDIT_DEPTH)) ? r_credit : r_credit + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_sel <= '0;
      r_ptr <= 3'(NUM_IN - 1);
      r_credit <= CW'(CREDIT_DEPTH);
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_sel <= w_sel_nx;
      r_ptr <= w_ptr_nx;
      r_credit <= w_credit_nx;
    end
  end
  assign bus.grant = r_grant;
  assign bus.sel = r_sel;
  assign bus.rd_en = w_go ? r_grant : '0;
  assign bus.valid_out = w_go;
  assign bus.credit_cnt = r_credit;
  assign bus.busy = (r_state == ACTIVE);
endmodule

// File: tb/tb_lbdr_output_allocator.sv
// tb_lbdr_output_allocator: directed vector table plus hand sequences for the output allocator
module tb_lbdr_output_allocator;
  import lbdr_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  lbdr_output_allocator_if #(.NUM_IN(5), .CW(3)) bus();
  lbdr_output_allocator dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [4:0] req, empty;
    logic [14:0] fid;
    logic cin;
    logic [4:0] g, rd;
    logic v;
    logic [2:0] cr;
    logic b;
  } vec_t;
  vec_t tbl [10];
  logic hp [5];
  logic [4:0] rd;
  int p;
  int rr_g [12] = '{0, 1, 1, 0, 2, 2, 0, 8, 8, 0, 1, 1};
  int rr_s [12] = '{0, 0, 0, 0, 1, 1, 0, 3, 3, 0, 0, 0};
  int st_cin [13] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0};
  int st_rd [13] = '{0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0};
  int st_cr [13] = '{4, 4, 3, 2, 1, 0, 0, 0, 1, 0, 0, 1, 1};
  int st_b [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [14:0] fids(input logic [2:0] f0, f1, f2, f3, f4);
    return {f4, f3, f2, f1, f0};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    bus.req = '0;
    bus.empty = '1;
    bus.flit_id = '0;
    bus.credit_in = 1'b0;
  endtask
  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset();
    #1;
    chk("rst grant", bus.grant, 0);
    chk("rst sel", bus.sel, 0);
    chk("rst rd_en", bus.rd_en, 0);
    chk("rst valid", bus.valid_out, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst abort", bus.abort, 0);
    chk("rst credit", bus.credit_cnt, 4);
    // single 3-flit packet on input 2, then payload-only request on input 1 plus credit saturation
    tbl[0] = '{5'b00100, 5'b11011, fids(0, 0, HEADER, 0, 0), 0, 5'b00000, 5'b00000, 0, 4, 0};
    tbl[1] = '{5'b00100, 5'b11011, fids(0, 0, HEADER, 0, 0), 0, 5'b00100, 5'b00100, 1, 4, 1};
    tbl[2] = '{5'b00100, 5'b11011, fids(0, 0, PAYLOAD, 0, 0), 0, 5'b00100, 5'b00100, 1, 3, 1};
    tbl[3] = '{5'b00100, 5'b11011, fids(0, 0, TAIL, 0, 0), 0, 5'b00100, 5'b00100, 1, 2, 1};
    tbl[4] = '{5'b00010, 5'b11101, fids(0, PAYLOAD, 0, 0, 0), 1, 5'b00000, 5'b00000, 0, 1, 0};
    tbl[5] = '{5'b00010, 5'b11101, fids(0, PAYLOAD, 0, 0, 0), 1, 5'b00000, 5'b00000, 0, 2, 0};
    tbl[6] = '{5'b00010, 5'b11101, fids(0, PAYLOAD, 0, 0, 0), 1, 5'b00000, 5'b00000, 0, 3, 0};
    tbl[7] = '{5'b00010, 5'b11101, fids(0, PAYLOAD, 0, 0, 0), 1, 5'b00000, 5'b00000, 0, 4, 0};
    tbl[8] = '{5'b00010, 5'b11101, fids(0, PAYLOAD, 0, 0, 0), 1, 5'b00000, 5'b00000, 0, 4, 0};
    tbl[9] = '{5'b00010, 5'b11101, fids(0, PAYLOAD, 0, 0, 0), 0, 5'b00000, 5'b00000, 0, 4, 0};
    for (int i = 0; i < 10; i++) begin
      bus.req = tbl[i].req;
      bus.empty = tbl[i].empty;
      bus.flit_id = tbl[i].fid;
      bus.credit_in = tbl[i].cin;
      #1;
      chk($sformatf("vec%0d grant", i), bus.grant, tbl[i].g);
      chk($sformatf("vec%0d rd_en", i), bus.rd_en, tbl[i].rd);
      chk($sformatf("vec%0d valid", i), bus.valid_out, tbl[i].v);
      chk($sformatf("vec%0d credit", i), bus.credit_cnt, tbl[i].cr);
      chk($sformatf("vec%0d busy", i), bus.busy, tbl[i].b);
      if (i == 1) chk("vec1 sel", bus.sel, 2);
      tick();
    end
    // round robin over inputs 0,1,3 with endless 2-flit packets
    do_reset();
    for (int j = 0; j < 5; j++) hp[j] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.req = 5'b01011;
      bus.empty = 5'b10100;
      bus.credit_in = 1'b1;
      bus.flit_id = fids(hp[0] ? TAIL : HEADER, hp[1] ? TAIL : HEADER, 0, hp[3] ? TAIL : HEADER, 0);
      #1;
      chk($sformatf("rr%0d grant", k), bus.grant, rr_g[k]);
      if (rr_g[k] != 0) chk($sformatf("rr%0d sel", k), bus.sel, rr_s[k]);
      rd = bus.rd_en;
      tick();
      for (int j = 0; j < 5; j++) if (rd[j]) hp[j] = ~hp[j];
    end
    #1;
    chk("rr credit", bus.credit_cnt, 4);
    // 6-flit packet on input 0 against 4 credits
    do_reset();
    p = 0;
    for (int k = 0; k < 13; k++) begin
      bus.req = 5'b00001;
      bus.empty = (p < 6) ? 5'b11110 : 5'b11111;
      bus.flit_id = fids(p == 0 ? HEADER : (p == 5 ? TAIL : PAYLOAD), 0, 0, 0, 0);
      bus.credit_in = st_cin[k][0];
      #1;
      chk($sformatf("stall%0d rd_en", k), bus.rd_en, st_rd[k]);
      chk($sformatf("stall%0d credit", k), bus.credit_cnt, st_cr[k]);
      chk($sformatf("stall%0d busy", k), bus.busy, st_b[k]);
      rd = bus.rd_en;
      tick();
      if (rd[0]) p++;
    end
    // reset after two flits of a 4-flit packet on input 3
    do_reset();
    bus.req = 5'b01000;
    bus.empty = 5'b10111;
    bus.flit_id = fids(0, 0, 0, HEADER, 0);
    tick();
    #1;
    chk("mid c1 rd_en", bus.rd_en, 5'b01000);
    tick();
    bus.flit_id = fids(0, 0, 0, PAYLOAD, 0);
    #1;
    chk("mid c2 rd_en", bus.rd_en, 5'b01000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 5'b10001;
    bus.empty = 5'b01110;
    bus.flit_id = fids(HEADER, 0, 0, 0, HEADER);
    #1;
    chk("mid grant", bus.grant, 0);
    chk("mid credit", bus.credit_cnt, 4);
    chk("mid busy", bus.busy, 0);
    tick();
    chk("mid regrant", bus.grant, 5'b00001);
    chk("mid resel", bus.sel, 0);
    // owner FIFO runs dry for 16 cycles with a header waiting on input 4
    do_reset();
    bus.req = 5'b10100;
    bus.empty = 5'b01011;
    bus.flit_id = fids(0, 0, HEADER, 0, HEADER);
    tick();
    chk("to grant", bus.grant, 5'b00100);
    bus.empty = 5'b01111;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk($sformatf("to%0d abort", k), bus.abort, 0);
    end
    tick();
`ifdef ALLOC_TIMEOUT_EN
    chk("to abort", bus.abort, 1);
    chk("to released", bus.grant, 0);
    chk("to busy", bus.busy, 0);
    tick();
    chk("to abort pulse", bus.abort, 0);
    chk("to next grant", bus.grant, 5'b10000);
    chk("to next sel", bus.sel, 4);
`else
    chk("to abort", bus.abort, 0);
    chk("to held", bus.grant, 5'b00100);
    chk("to busy", bus.busy, 1);
    tick();
    tick();
    chk("to still busy", bus.busy, 1);
    chk("to credit", bus.credit_cnt, 4);
`endif
    idle_in();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lbdr_output_allocator.md
Name: lbdr_output_allocator

Overview:
- Per-output-port switch allocator for the mesh router. Instantiated once per output direction (N/E/W/S/L), downstream of the five input-port LBDR units.
- Takes each input's LBDR port bit for this output and arbitrates round-robin on HEADER flits.
- Locks the winner until its TAIL flit has been forwarded, and gates forwarding on a downstream credit counter.

Parameters:
- NUM_IN, 5, number of requesting input ports (index 0=N, 1=E, 2=W, 3=S, 4=L).
- CREDIT_DEPTH, 4, downstream buffer slots; reset value of the credit counter.
- CW, 3, credit counter width; must satisfy 2^CW > CREDIT_DEPTH.
- TIMEOUT_CYC, 16, watchdog limit in cycles; used only with ALLOC_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req  input  NUM_IN  LBDR output bit for this port, one per input
- empty  input  NUM_IN  input FIFO empty flags
- flit_id  input  3*NUM_IN  head-flit id per input; input i occupies bits [3i+2:3i]
- credit_in  input  1  one downstream slot freed this cycle
- grant  output  NUM_IN  registered one-hot owner of this output
- sel  output  3  registered binary index of the owner (crossbar select)
- rd_en  output  NUM_IN  pop strobe to the owner's input FIFO
- valid_out  output  1  flit crosses the crossbar this cycle
- credit_cnt  output  CW  current downstream credits
- busy  output  1  high in ACTIVE
- abort  output  1  watchdog pulse (0 when ALLOC_TIMEOUT_EN is undefined)

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - state=IDLE, grant=0, sel=0, rd_en=0, valid_out=0, busy=0, abort=0.
  - credit_cnt=CREDIT_DEPTH.
  - rr_ptr=NUM_IN-1, so input 0 has first priority.
- Eligibility: input i is eligible when req[i] & ~empty[i] & flit_id_i==HEADER.
- IDLE:
  - If any input is eligible, pick the first eligible index scanning rr_ptr+1, rr_ptr+2, … modulo NUM_IN.
  - On the next edge: grant one-hot set, sel=index, state=ACTIVE.
  - Arbitration latency is 1 cycle. No flit moves in IDLE.
- ACTIVE:
  - rd_en[g] = ~empty[g] & (credit_cnt != 0). This is combinational from registered state. All other rd_en bits are 0.
  - valid_out = |rd_en.
  - A packet with F flits and sufficient credit completes in F cycles after the grant.
- Release:
  - A cycle with rd_en[g]=1 and flit_id_g==TAIL transfers the tail.
  - On the next edge: state=IDLE, grant=0, rr_ptr=g.
  - Re-arbitration happens in IDLE on the following cycle, so there is a 1-cycle bubble between packets.
- Credits:
  - valid_out alone: credit_cnt decrements.
  - credit_in alone: credit_cnt increments.
  - Both in the same cycle: credit_cnt unchanged.
  - credit_in at CREDIT_DEPTH is ignored (saturate).
  - credit_cnt==0 stalls rd_en without leaving ACTIVE.
- Requests from other inputs during ACTIVE are ignored; req and flit_id of the owner are not rechecked after the grant.
- A non-HEADER flit at an input head never wins arbitration.
- rst mid-packet: abandons ownership and restores credits to CREDIT_DEPTH. Upstream flushing is outside this block.
- busy = (state==ACTIVE).

Optional Feature:
- Macro: ALLOC_TIMEOUT_EN.
- Defined:
  - A CW-independent counter clears on every rd_en and increments each ACTIVE cycle with rd_en==0.
  - On reaching TIMEOUT_CYC: abort pulses for 1 cycle, state=IDLE, grant=0, rr_ptr=g. Credits are unchanged.
  - Counter clears on entry to ACTIVE and on rst.
- Undefined: abort is tied 0, no counter exists, and ACTIVE persists indefinitely.

Decomposition:
- Shared package lbdr_pkg holds:
  - Flit codes: HEADER=3'b001, PAYLOAD=3'b010, TAIL=3'b100.
  - Port index constants: PORT_N=0, PORT_E=1, PORT_W=2, PORT_S=3, PORT_L=4.
  - State enum alloc_state_t {IDLE, ACTIVE}.
- One sub-module: rr_arbiter. Purely combinational; inputs elig[NUM_IN] and ptr; outputs a one-hot winner and its binary index.

Test Plan:
- Single packet: rst, then input 2 presents HEADER, PAYLOAD, TAIL with req[2]=1 and credits=4.
  - Cycle 1 after request: grant=5'b00100, sel=2.
  - Next 3 cycles: rd_en[2]=1.
  - Then credit_cnt=1, state=IDLE, grant=0.
- Round-robin: inputs 0, 1 and 3 all eligible continuously with credit_in tied 1.
  - Grants occur in order 0, 1, 3, 0.
  - Each packet is followed by exactly one idle cycle.
- Credit stall: CREDIT_DEPTH=4 and a 6-flit packet with credit_in=0.
  - rd_en stops after 4 flits with credit_cnt=0.
  - One credit_in pulse allows exactly one more flit.
  - Simultaneous valid_out and credit_in holds the count.
- Non-header filter and saturation:
  - req[1]=1 with flit_id_1=PAYLOAD: no grant ever issued.
  - credit_in pulses at credit_cnt=4: value stays 4.
- Reset mid-packet: rst after 2 of 4 flits.
  - Next cycle: grant=0, credit_cnt=4, rr_ptr=4, so input 0 wins next.
- With ALLOC_TIMEOUT_EN: owner FIFO empty for 16 consecutive ACTIVE cycles.
  - abort=1 for exactly one cycle, then grant=0, and a pending HEADER elsewhere is granted next.
